// File: rtl/dmem_wbuf_if.sv
// Core-side store/load port of the buffered data memory; ADDR_CHECK_EN adds addr_err.
// master = core (drives stores/loads), slave = dmem_wbuf.
interface dmem_wbuf_if;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        stall;
    logic        idle;
`ifdef ADDR_CHECK_EN
    logic        addr_err;

    modport master (output memwrite, dataadr, writedata,
                    input  readdata, stall, idle, addr_err);
    modport slave  (input  memwrite, dataadr, writedata,
                    output readdata, stall, idle, addr_err);
`else
    modport master (output memwrite, dataadr, writedata,
                    input  readdata, stall, idle);
    modport slave  (input  memwrite, dataadr, writedata,
                    output readdata, stall, idle);
`endif
endinterface

// File: rtl/dmem_wbuf.sv
// Data memory with a DEPTH-entry posted write buffer draining into a slow RAM port; optional ADDR_CHECK_EN.
// Store reaches RAM two edges after acceptance when idle; stall holds the core while the buffer is full.
module dmem_wbuf #(
    parameter int DEPTH       = 4,
    parameter int AW          = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    dmem_wbuf_if.slave bus
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT} state_t;

    state_t         state_q;
    logic [WCW-1:0] wait_q;
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic [AW-1:0]  buf_adr_q [DEPTH];
    logic [31:0]    buf_dat_q [DEPTH];
    logic [31:0]    ram_q [2**AW];

    logic          store_ok, push, pop;
    logic [AW-1:0] word_idx;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [31:0]   ram_wd;
    logic [PW-1:0] fwd_idx;
    logic [31:0]   rdata;

    assign word_idx  = bus.dataadr[AW+1:2];
    assign bus.stall = (count_q == CW'(DEPTH));
    assign bus.idle  = (count_q == '0) && (state_q == S_IDLE);

`ifdef ADDR_CHECK_EN
    logic err_q;

    assign store_ok     = (bus.dataadr[1:0] == 2'b00) && (bus.dataadr[31:AW+2] == '0);
    assign bus.addr_err = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (bus.memwrite && !store_ok) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_adr_bits;

    assign store_ok        = 1'b1;
    assign unused_adr_bits = ^{bus.dataadr[31:AW+2], bus.dataadr[1:0]};
`endif

    assign push    = bus.memwrite && !bus.stall && store_ok;
    assign pop     = (state_q == S_WRITE);
    assign count_d = count_q + CW'(push) - CW'(pop);

    assign ram_we = pop;
    assign ram_wa = buf_adr_q[rd_ptr_q];
    assign ram_wd = buf_dat_q[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Drain FSM: one RAM write, then WAIT_CYCLES of port recovery.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) state_q <= S_WRITE;
                end
                S_WRITE: begin
                    if (WAIT_CYCLES > 0) begin
                        state_q <= S_WAIT;
                        wait_q  <= WCW'(WAIT_CYCLES - 1);
                    end else begin
                        state_q <= (count_d != '0) ? S_WRITE : S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (wait_q == '0) begin
                        state_q <= (count_q != '0) ? S_WRITE : S_IDLE;
                    end else begin
                        wait_q <= wait_q - WCW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // RAM contents and buffer payload are deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_adr_q[wr_ptr_q] <= word_idx;
            buf_dat_q[wr_ptr_q] <= bus.writedata;
        end
        if (ram_we) ram_q[ram_wa] <= ram_wd;
    end

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        rdata   = ram_q[word_idx];
        fwd_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (buf_adr_q[fwd_idx] == word_idx)) begin
                rdata = buf_dat_q[fwd_idx];
            end
        end
    end

    assign bus.readdata = rdata;
endmodule

// File: tb/tb_dmem_wbuf.sv
// Bench for dmem_wbuf: instance A (DEPTH 4, WAIT 3) and instance B (DEPTH 2, WAIT 0).
module tb_dmem_wbuf;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_wbuf_if ba();
    dmem_wbuf_if bb();

    dmem_wbuf #(.DEPTH(4), .AW(6), .WAIT_CYCLES(3)) u_a (.clk(clk), .reset(reset), .bus(ba));
    dmem_wbuf #(.DEPTH(2), .AW(6), .WAIT_CYCLES(0)) u_b (.clk(clk), .reset(reset), .bus(bb));

`ifdef ADDR_CHECK_EN
    localparam bit ACHK = 1'b1;
`else
    localparam bit ACHK = 1'b0;
`endif

    typedef struct packed {
        logic [5:0]  wa;
        logic [31:0] wd;
    } wr_t;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] rd;
        logic        stall;
        logic        idle;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    wr_t  qa[$];
    wr_t  qb[$];
    vec_t tv [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic bit store_ok(input logic [31:0] adr);
        if (ACHK) return (adr[1:0] == 2'b00) && (adr[31:8] == 24'd0);
        return 1'b1;
    endfunction

    // One cycle: drive after the edge, sample at negedge, feed and drain the scoreboards.
    task automatic step(input logic a_we, input logic [31:0] a_adr, input logic [31:0] a_wd,
                        input logic b_we, input logic [31:0] b_adr, input logic [31:0] b_wd);
        wr_t e;
        @(posedge clk);
        #1;
        ba.memwrite  = a_we;
        ba.dataadr   = a_adr;
        ba.writedata = a_wd;
        bb.memwrite  = b_we;
        bb.dataadr   = b_adr;
        bb.writedata = b_wd;
        @(negedge clk);
        if (!reset) begin
            if (ba.memwrite && !ba.stall && store_ok(ba.dataadr)) begin
                e.wa = ba.dataadr[7:2];
                e.wd = ba.writedata;
                qa.push_back(e);
            end
            if (bb.memwrite && !bb.stall && store_ok(bb.dataadr)) begin
                e.wa = bb.dataadr[7:2];
                e.wd = bb.writedata;
                qb.push_back(e);
            end
            if (u_a.ram_we) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_a: RAM write word %0d data %h, required no write", u_a.ram_wa, u_a.ram_wd);
                end else begin
                    e = qa.pop_front();
                    check("sb_a addr", 32'(u_a.ram_wa), 32'(e.wa));
                    check("sb_a data", u_a.ram_wd, e.wd);
                end
            end
            if (u_b.ram_we) begin
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_b: RAM write word %0d data %h, required no write", u_b.ram_wa, u_b.ram_wd);
                end else begin
                    e = qb.pop_front();
                    check("sb_b addr", 32'(u_b.ram_wa), 32'(e.wa));
                    check("sb_b data", u_b.ram_wd, e.wd);
                end
            end
        end
    endtask

    task automatic sa(input logic we, input logic [31:0] adr, input logic [31:0] wd);
        step(we, adr, wd, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic wait_idle_a(input string name);
        int n;
        n = 0;
        while (!ba.idle && n < 200) begin
            sa(1'b0, 32'd0, 32'd0);
            n++;
        end
        check(name, 32'(ba.idle), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_st;
        int         n;
        logic       we_b;
        logic [31:0] adr_b, wd_b;

        // we, adr, wd, chk_rd, rd, stall, idle
        tv[0]  = '{1'b1, 32'd84, 32'd7, 1'b0, 32'd0, 1'b0, 1'b1};
        tv[1]  = '{1'b0, 32'd84, 32'd0, 1'b1, 32'd7, 1'b0, 1'b0};
        tv[2]  = '{1'b0, 32'd84, 32'd0, 1'b1, 32'd7, 1'b0, 1'b0};
        tv[3]  = '{1'b0, 32'd84, 32'd0, 1'b1, 32'd7, 1'b0, 1'b0};
        tv[4]  = '{1'b0, 32'd84, 32'd0, 1'b1, 32'd7, 1'b0, 1'b0};
        tv[5]  = '{1'b0, 32'd84, 32'd0, 1'b1, 32'd7, 1'b0, 1'b0};
        tv[6]  = '{1'b0, 32'd84, 32'd0, 1'b1, 32'd7, 1'b0, 1'b1};
        tv[7]  = '{1'b1, 32'd80, 32'd5, 1'b0, 32'd0, 1'b0, 1'b1};
        tv[8]  = '{1'b1, 32'd80, 32'd9, 1'b1, 32'd5, 1'b0, 1'b0};
        tv[9]  = '{1'b0, 32'd80, 32'd0, 1'b1, 32'd9, 1'b0, 1'b0};
        tv[10] = '{1'b0, 32'd80, 32'd0, 1'b1, 32'd9, 1'b0, 1'b0};
        tv[11] = '{1'b0, 32'd80, 32'd0, 1'b1, 32'd9, 1'b0, 1'b0};
        tv[12] = '{1'b0, 32'd80, 32'd0, 1'b1, 32'd9, 1'b0, 1'b0};
        tv[13] = '{1'b0, 32'd80, 32'd0, 1'b1, 32'd9, 1'b0, 1'b0};
        tv[14] = '{1'b0, 32'd80, 32'd0, 1'b1, 32'd9, 1'b0, 1'b0};
        tv[15] = '{1'b0, 32'd80, 32'd0, 1'b1, 32'd9, 1'b0, 1'b0};
        tv[16] = '{1'b0, 32'd80, 32'd0, 1'b1, 32'd9, 1'b0, 1'b0};
        tv[17] = '{1'b0, 32'd80, 32'd0, 1'b1, 32'd9, 1'b0, 1'b1};

        reset        = 1'b1;
        ba.memwrite  = 1'b0;
        ba.dataadr   = 32'd0;
        ba.writedata = 32'd0;
        bb.memwrite  = 1'b0;
        bb.dataadr   = 32'd0;
        bb.writedata = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst stall_a", 32'(ba.stall), 32'd0);
        check("rst idle_a",  32'(ba.idle),  32'd1);
        check("rst stall_b", 32'(bb.stall), 32'd0);
        check("rst idle_b",  32'(bb.idle),  32'd1);
`ifdef ADDR_CHECK_EN
        check("rst addr_err", 32'(ba.addr_err), 32'd0);
`endif

        // Forwarding, drain latency and same-address overwrite.
        for (int i = 0; i < 18; i++) begin
            sa(tv[i].we, tv[i].adr, tv[i].wd);
            check($sformatf("v%0d stall", i), 32'(ba.stall), 32'(tv[i].stall));
            check($sformatf("v%0d idle", i),  32'(ba.idle),  32'(tv[i].idle));
            if (tv[i].chk_rd) check($sformatf("v%0d rd", i), ba.readdata, tv[i].rd);
        end

        // Back-to-back stores into A until the buffer fills; a stalled store is held.
        exp_st = 8'b0110_0000;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            sa(1'b1, 32'(4 * n), 32'(n + 1));
            check($sformatf("fill c%0d stall", c), 32'(ba.stall), 32'(exp_st[c]));
            if (!ba.stall) n++;
        end
        check("fill accepted", 32'(n), 32'd6);
        sa(1'b0, 32'd0, 32'd0);
        wait_idle_a("fill drained");
        for (int k = 0; k < 6; k++) begin
            sa(1'b0, 32'(4 * k), 32'd0);
            check($sformatf("fill rd%0d", k), ba.readdata, 32'(k + 1));
        end

        // Three stores pending, reset while the drain sits in WAIT.
        sa(1'b1, 32'd0, 32'd100);
        sa(1'b1, 32'd4, 32'd101);
        sa(1'b1, 32'd8, 32'd102);
        sa(1'b0, 32'd0, 32'd0);
        check("pre-rst idle", 32'(ba.idle), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        qa.delete();
        qb.delete();
        @(negedge clk);
        check("mid-rst stall", 32'(ba.stall), 32'd0);
        check("mid-rst idle",  32'(ba.idle),  32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        sa(1'b0, 32'd0, 32'd0);
        check("post-rst rd0", ba.readdata, 32'd100);
        check("post-rst idle", 32'(ba.idle), 32'd1);
        sa(1'b0, 32'd4, 32'd0);
        check("post-rst rd4", ba.readdata, 32'd2);
        sa(1'b0, 32'd8, 32'd0);
        check("post-rst rd8", ba.readdata, 32'd3);

        // B: one primer store, then a continuous stream with simultaneous push/pop.
        for (int k = 0; k < 11; k++) begin
            we_b  = (k != 1) && (k <= 8);
            adr_b = (k == 0) ? 32'd64 : 32'(64 + 4 * (k - 1));
            wd_b  = (k == 0) ? 32'h500 : 32'(32'h500 + k - 1);
            step(1'b0, 32'd0, 32'd0, we_b, adr_b, wd_b);
            check($sformatf("strm k%0d stall", k), 32'(bb.stall), 32'd0);
            check($sformatf("strm k%0d we", k), 32'(u_b.ram_we), 32'((k >= 2) && (k <= 9)));
        end
        check("strm idle", 32'(bb.idle), 32'd1);
        for (int j = 0; j < 8; j++) begin
            step(1'b0, 32'd0, 32'd0, 1'b0, 32'(64 + 4 * j), 32'd0);
            check($sformatf("strm rd%0d", j), bb.readdata, 32'(32'h500 + j));
        end

        // Misaligned and out-of-range stores to word 21.
        sa(1'b1, 32'd85, 32'hAB);
        sa(1'b1, 32'd340, 32'hCD);
        sa(1'b0, 32'd84, 32'd0);
        check("bad idle", 32'(ba.idle), 32'(ACHK));
`ifdef ADDR_CHECK_EN
        check("bad addr_err", 32'(ba.addr_err), 32'd1);
`endif
        wait_idle_a("bad drained");
        sa(1'b0, 32'd84, 32'd0);
        check("bad rd84", ba.readdata, ACHK ? 32'd7 : 32'hCD);

        check("sb_a empty", 32'(qa.size()), 32'd0);
        check("sb_b empty", 32'(qb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
